// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the 4:1 mux scan sequencer.
//   NUM_CH / SEL_W : channel count and select width of the downstream mux
//   CNT_W          : width of the settle counter (SETTLE legal 0..15)
//   state_t        : sequencer state encoding
package mux_scan_sequencer_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mux_next_channel.sv
// Combinational channel picker for the scan sequencer.
//   mask       : channel enables, bit n = channel n
//   ch         : currently selected channel
//   from_start : 1 = pick the lowest set bit overall, 0 = lowest set bit above ch
//   next_ch    : chosen channel (0 when none found)
//   found      : a qualifying channel exists
module mux_next_channel
    import mux_scan_sequencer_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  ch,
    input  logic              from_start,
    output logic [SEL_W-1:0]  next_ch,
    output logic              found
);

    always_comb begin
        next_ch = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && mask[i[SEL_W-1:0]] && (from_start || i > 32'(ch))) begin
                found   = 1'b1;
                next_ch = i[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer driving the select lines of a 4:1 single-bit mux.
// Visits enabled channels in ascending order, waits SETTLE cycles per
// channel, samples mux_y into a 4-bit frame and hands the frame off on a
// valid/ready handshake, optionally rescanning continuously.
//   clk, rst             : clock, synchronous active-high reset
//   start, ch_mask       : scan request and channel enables (latched on accept)
//   continuous           : rescan with the latched mask after each handshake
//   mux_y                : mux output being sampled
//   S1, S0               : mux select (MSB, LSB)
//   busy                 : high whenever not idle
//   sample_valid/_ch/_bit: one-cycle report of each captured sample
//   frame_valid/ready    : frame handshake; frame bit n = channel n sample
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              continuous,
    input  logic              mux_y,
    output logic              S0,
    output logic              S1,
    output logic              busy,
    output logic              sample_valid,
    output logic [SEL_W-1:0]  sample_ch,
    output logic              sample_bit,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [NUM_CH-1:0] frame
);

    // With SETTLE=0 a new channel goes straight to sampling.
    localparam state_t ENTER_ST = state_t'((SETTLE == 0) ? ST_SAMPLE : ST_SETTLE);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t            state;
    logic [NUM_CH-1:0] mask_q;
    logic [CNT_W-1:0]  cnt;
    logic [SEL_W-1:0]  sel;

    logic [NUM_CH-1:0] search_mask;
    logic              from_start;
    logic [SEL_W-1:0]  next_ch;
    logic              found;

    // One picker serves all states: IDLE looks at the live mask, DONE
    // restarts from the latched mask, SAMPLE advances past the current channel.
    assign search_mask = (state == ST_IDLE) ? ch_mask : mask_q;
    assign from_start  = (state != ST_SAMPLE);

    mux_next_channel u_next (
        .mask       (search_mask),
        .ch         (sel),
        .from_start (from_start),
        .next_ch    (next_ch),
        .found      (found)
    );

    assign S1 = sel[1];
    assign S0 = sel[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            mask_q       <= '0;
            cnt          <= '0;
            sel          <= '0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_bit   <= 1'b0;
            frame_valid  <= 1'b0;
            frame        <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mask_q <= ch_mask;
                        frame  <= '0;
                        busy   <= 1'b1;
                        if (found) begin
                            sel   <= next_ch;
                            cnt   <= '0;
                            state <= ENTER_ST;
                        end else begin
                            state       <= ST_DONE;
                            frame_valid <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    frame[sel]   <= mux_y;
                    sample_valid <= 1'b1;
                    sample_ch    <= sel;
                    sample_bit   <= mux_y;
                    if (found) begin
                        sel   <= next_ch;
                        cnt   <= '0;
                        state <= ENTER_ST;
                    end else begin
                        state       <= ST_DONE;
                        frame_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // frame_valid low while in DONE only happens on the
                    // continuous empty-mask loop: re-present the zero frame.
                    if (!frame_valid) begin
                        frame_valid <= 1'b1;
                    end else if (frame_ready) begin
                        frame_valid <= 1'b0;
                        if (continuous && found) begin
                            frame <= '0;
                            sel   <= next_ch;
                            cnt   <= '0;
                            state <= ENTER_ST;
                        end else if (!continuous) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Control stage directly upstream of the team's 4:1 single-bit channel multiplexer.
- Drives the mux select pair (S1 = MSB, S0 = LSB) through the enabled channels in ascending order.
- After a programmable settle time, samples the mux output Y and assembles a 4-bit frame, one bit per channel.
- Delivers the frame to downstream logic over a valid/ready handshake, optionally rescanning continuously.

Parameters:
- SETTLE, 2, cycles the select is held before sampling Y (legal 0..15).

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a scan; accepted only in IDLE.
- ch_mask  in  4  channel enables, bit n = channel n; latched when start is accepted.
- continuous  in  1  sampled at each frame handshake; 1 = restart scan with the latched mask.
- mux_y  in  1  the Y output of the 4:1 mux.
- S0  out  1  select LSB to the mux.
- S1  out  1  select MSB to the mux.
- busy  out  1  high in every state except IDLE.
- sample_valid  out  1  one-cycle pulse when mux_y is captured.
- sample_ch  out  2  channel captured on sample_valid.
- sample_bit  out  1  mux_y value captured on sample_valid.
- frame_valid  out  1  frame available; held until frame_ready.
- frame_ready  in  1  downstream accept.
- frame  out  4  bit n = sampled value of channel n; 0 for masked channels.

Behaviour:
- Reset: state IDLE. S1, S0, busy, sample_valid, sample_ch, sample_bit, frame_valid and frame are all 0. Latched mask and settle counter are cleared. Reset in any state, including mid-scan or while frame_valid is high, aborts immediately with no frame delivered.
- All outputs are registered.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 latches ch_mask and clears the frame register.
  - If mask != 0: ch = lowest set bit; {S1,S0} <= ch; go to SETTLE.
  - If mask == 0: go directly to DONE; the frame is 0.
- SETTLE: hold {S1,S0}; count SETTLE cycles, then go to SAMPLE. With SETTLE=0 the state is skipped (IDLE/SAMPLE transition straight to SAMPLE).
- SAMPLE (one cycle):
  - frame[ch] <= mux_y; sample_valid pulses next cycle with sample_ch=ch and sample_bit=mux_y.
  - Next ch = lowest set mask bit above the current ch. If one exists: update {S1,S0}, go to SETTLE. If none: go to DONE.
- DONE:
  - frame_valid=1; frame stable.
  - On frame_valid & frame_ready: frame_valid <= 0 next cycle.
  - If continuous=1 and latched mask != 0: clear frame, restart at the lowest set bit (as IDLE start).
  - If continuous=1 and latched mask == 0: re-enter DONE, producing a 0 frame every 2 cycles.
  - Else go to IDLE.
- Latency: start-accept cycle = cycle 0. frame_valid rises at cycle popcount(mask)*(SETTLE+1)+1. Example: SETTLE=2, mask=1111 gives frame_valid at cycle 13.
- start while busy is ignored; it is neither queued nor does it alter the mask.
- ch_mask changes mid-scan have no effect until the next accepted start.
- {S1,S0} keeps the last selected channel in DONE and IDLE; it changes only when a new channel is entered.
- Channel order is strictly ascending; there is no wrap within a frame.

Decomposition:
- Shared package contents:
  - NUM_CH=4 and SEL_W=2 constants.
  - state enum {IDLE, SETTLE, SAMPLE, DONE}.
  - Settle counter width: 4 bits.
- One sub-module: mux_next_channel.
  - Combinational.
  - Inputs: mask[3:0], current ch[1:0], a "from_start" flag.
  - Outputs: next ch and found flag.
  - Finds the lowest set bit strictly above ch, or the lowest set bit overall when from_start.

Test Plan:
- Reset then SETTLE=2, mask=1111, mux_y driven as a function of {S1,S0} giving 1,0,1,1 for ch0..3, frame_ready=1 → sample_valid pulses for ch 0,1,2,3; frame_valid at cycle 13; frame=4'b1101; then IDLE.
- mask=0101, SETTLE=0, mux_y=1 on all channels → select visits 00 then 10 only; frame_valid at cycle 3; frame=4'b0101.
- mask=0000, start → frame_valid at cycle 1, frame=0; no sample_valid pulses.
- Full scan with frame_ready=0 for 5 cycles → frame_valid and frame held stable; busy=1 throughout; start pulses ignored; accept → IDLE.
- continuous=1, mask=1000, SETTLE=1 → back-to-back frames; select stays 11; mux_y toggled between frames is reflected in frame[3].
- rst asserted during SETTLE of ch2 → next cycle all outputs 0, state IDLE; a following start performs a clean full scan.
